booth_datapath: RTL
===================

// Module: booth_datapath
// PURPOSE
//  Datapath for the sequential Booth signed multiplier; the responder to the multiply controller.
//  Consumes load strobes, step enable and ALU function select; returns the 6-bit status word the controller sequences on.
//  Holds M (multiplicand), A (accumulator), Q (multiplier) and Q_1, plus the iteration counter.
// PARAMETERS
//  WIDTH   8   operand width; product is 2*WIDTH; counter is $clog2(WIDTH+1) bits
// PORTS
//  clk      in   1        clock; all state updates on posedge (controller acts on negedge)
//  reset    in   1        synchronous, active-low reset
//  din_m    in   WIDTH    multiplicand, captured on xld
//  din_q    in   WIDTH    multiplier, captured on pld
//  ald      in   1        clear A and Q_1 to 0
//  pld      in   1        load Q <= din_q
//  xld      in   1        load M <= din_m
//  cntld    in   1        load counter <= WIDTH
//  control  in   1        perform one Booth step
//  funsel   in   3        ALU op for step: 100 ADD A+M, 110 SUB A-M, others NOP; funsel[0] ignored
//  status   out  6        [0]=Q_1 [1]=Q[0] [2]=Q[1] [3]=M[WIDTH-1] [4]=ovf [5]=(counter==0)
//  product  out  2*WIDTH  {A,Q}, combinational from registers
// BEHAVIOUR
//  - reset low at posedge: M,A,Q,Q_1,counter,ovf <= 0. Next cycle: status=6'b100000, product=0.
//  - reset has priority over every strobe. Reset mid-multiply abandons the operation with no residue.
//  - Loads: ald, pld, xld, cntld are independent; any combination in one cycle takes effect together.
//  - Step: when control=1, no load strobe is active and counter!=0:
//      R = ALU(A,M,funsel) (WIDTH bits, wraps mod 2^WIDTH);
//      {A,Q,Q_1} <= arithmetic right shift of {R,Q,Q_1} (sign bit R[WIDTH-1] replicated);
//      counter <= counter-1.
//  - control=1 together with any load strobe: the step is suppressed; the loads alone occur.
//  - control=1 with counter==0: no change to any register (no underflow); status[5] stays 1.
//  - status/product: combinational from registers, valid one posedge after the update.
//    A full multiply is WIDTH steps after ald+pld+xld+cntld.
//  - Reserved funsel codes act as NOP for ALU (shift and decrement still occur).
// CONFIGURATION
//  BOOTH_DP_OVF_EN defined:
//    status[4] is sticky; set on any step whose ADD/SUB result overflows signed WIDTH range
//    (operand signs equal, result sign differs); cleared by ald or reset.
//  Not defined: status[4] tied 0; no overflow logic synthesized.
// STRUCTURE
//  - booth_pkg:
//    FN_ADD=3'b100, FN_SUB=3'b110;
//    ST_QM1=0, ST_Q0=1, ST_Q1=2, ST_MSGN=3, ST_OVF=4, ST_DONE=5 status bit indices.
//  - Sub-module booth_alu: combinational ADD/SUB/NOP on WIDTH bits with signed-overflow output.
//    Registers, counter and shifter stay in booth_datapath.
// TESTING (WIDTH=8; bench drives Booth funsel from status[1:0]: 10->SUB, 01->ADD, else NOP)
//  1 reset low 1 cycle after random loads -> status=6'b100000, product=16'h0000
//  2 M=8'h03, Q=8'h05, ald/pld/xld/cntld then 8 steps -> product=16'h000F, status[5]=1
//  3 M=8'hFC, Q=8'h07, 8 steps -> product=16'hFFE4 (-28)
//  4 control held for 10 steps after load -> register state after step 8 unchanged for steps 9-10, counter stays 0
//  5 control+pld same cycle -> Q=din_q, counter unchanged, A unchanged; reset low after step 3 -> all zero next cycle
//  6 M=8'h80, Q=8'h80, 8 steps -> status[4]=1 with BOOTH_DP_OVF_EN, 0 without; cleared by next ald

Source files
------------

// File: rtl/booth_pkg.sv
// booth_pkg: shared ALU codes and status bit indices for the Booth multiplier datapath
package booth_pkg;
  localparam logic [2:0] FN_ADD = 3'b100;
  localparam logic [2:0] FN_SUB = 3'b110;
  localparam int ST_QM1  = 0;
  localparam int ST_Q0   = 1;
  localparam int ST_Q1   = 2;
  localparam int ST_MSGN = 3;
  localparam int ST_OVF  = 4;
  localparam int ST_DONE = 5;
endpackage

// File: rtl/booth_alu.sv
// booth_alu: combinational ADD/SUB/NOP on the accumulator with signed-overflow flag
module booth_alu
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] m,
  input  logic [2:0]       funsel,
  output logic [WIDTH-1:0] r,
  output logic             ovf
);
  logic is_add, is_sub;
  // funsel[0] is a don't-care, so it is masked off before decoding
  assign is_add = (funsel & 3'b110) == FN_ADD;
  assign is_sub = (funsel & 3'b110) == FN_SUB;
  always_comb begin
    r = is_add ? a + m : is_sub ? a - m : a;
    ovf = is_add ? (a[WIDTH-1] == m[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1])
        : is_sub ? (a[WIDTH-1] != m[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1])
        : 1'b0;
  end
endmodule

// File: rtl/booth_datapath.sv
// booth_datapath: M/A/Q/Q_1 registers, step counter and shifter for the sequential Booth multiplier.
// Optional BOOTH_DP_OVF_EN adds a sticky signed-overflow flag on status[4].
module booth_datapath
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   din_m,
  input  logic [WIDTH-1:0]   din_q,
  input  logic               ald,
  input  logic               pld,
  input  logic               xld,
  input  logic               cntld,
  input  logic               control,
  input  logic [2:0]         funsel,
  output logic [5:0]         status,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] m, a, q, r;
  logic             q_1, alu_ovf, ovf, step;
  logic [CW-1:0]    cnt;
  booth_alu #(.WIDTH(WIDTH)) u_alu (.a(a), .m(m), .funsel(funsel), .r(r), .ovf(alu_ovf));
  // any load strobe wins over a step in the same cycle
  assign step = control && !(ald || pld || xld || cntld) && cnt != '0;
  always_ff @(posedge clk) begin
    if (!reset) begin
      m <= '0;
      a <= '0;
      q <= '0;
      q_1 <= 1'b0;
      cnt <= '0;
    end else begin
      if (ald) begin
        a <= '0;
        q_1 <= 1'b0;
      end
      if (pld) q <= din_q;
      if (xld) m <= din_m;
      if (cntld) cnt <= CW'(WIDTH);
      if (step) begin
        {a, q, q_1} <= {r[WIDTH-1], r, q};
        cnt <= cnt - 1'b1;
      end
    end
  end
`ifdef BOOTH_DP_OVF_EN
  always_ff @(posedge clk) begin
    if (!reset || ald) ovf <= 1'b0;
    else if (step && alu_ovf) ovf <= 1'b1;
  end
`else
  logic unused_ovf;
  assign unused_ovf = alu_ovf;
  assign ovf = 1'b0;
`endif
  always_comb begin
    status = '0;
    status[ST_QM1] = q_1;
    status[ST_Q0] = q[0];
    status[ST_Q1] = q[1];
    status[ST_MSGN] = m[WIDTH-1];
    status[ST_OVF] = ovf;
    status[ST_DONE] = cnt == '0;
  end
  assign product = {a, q};
endmodule
